// File: rtl/uart_defs_pkg.sv
// ---------------------------------------------------------------------------
// uart_defs_pkg : frame constants and FSM encodings shared by UART blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_defs_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_STOP_BITS    = 2;
  localparam int UART_CLKS_PER_BIT = 8464;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP1  = 3'd4;
  localparam uart_state_t ST_STOP2  = 3'd5;

  function automatic logic parity_bit(input logic [7:0] i_byte, input logic i_odd);
    return (^i_byte) ^ i_odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick : bit-period down-counter, one-cycle tick on the last cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 8464
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            c_cw     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cw-1:0] c_reload = c_cw'(CLKS_PER_BIT - 1);

  logic [c_cw-1:0] r_cnt;

  // Restart preloads so the first bit after a restart lasts a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == '0)) begin
      r_cnt <= c_reload;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0) && !i_restart;

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : 8-bit, parity, 2-stop UART transmitter with one-entry holding reg
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx
  import uart_defs_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);

  uart_state_t r_state;
  uart_state_t w_state_next;
  logic [7:0]  r_hold;
  logic        r_hold_full;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic [2:0]  r_bit_idx;
  logic        r_parity;
  logic        r_tx;
  logic        w_tx_next;
  logic        w_tick;
  logic        w_accept;
  logic        w_load;
  logic        w_last_data;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .i_restart(r_state == ST_IDLE),
    .o_tick   (w_tick)
  );

  assign w_accept    = data_valid && !r_hold_full;
  assign w_load      = r_hold_full && ((r_state == ST_IDLE) || ((r_state == ST_STOP2) && w_tick));
  assign w_last_data = (r_bit_idx == 3'(UART_DATA_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (r_hold_full) w_state_next = ST_START;
      ST_START:  if (w_tick) w_state_next = ST_DATA;
      ST_DATA:   if (w_tick && w_last_data) w_state_next = ST_PARITY;
      ST_PARITY: if (w_tick) w_state_next = ST_STOP1;
      ST_STOP1:  if (w_tick) w_state_next = ST_STOP2;
      ST_STOP2:  if (w_tick) w_state_next = r_hold_full ? ST_START : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // The line value is computed for the state being entered so tx can be registered.
  always_comb begin
    w_shift_next = r_shift;
    if (w_load) begin
      w_shift_next = r_hold;
    end else if ((r_state == ST_DATA) && w_tick) begin
      w_shift_next = r_shift >> 1;
    end
    w_tx_next = 1'b1;
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = r_parity;
      default:   w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_parity    <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      r_tx    <= w_tx_next;
      r_shift <= w_shift_next;
      if (w_load) begin
        r_hold_full <= 1'b0;
        r_bit_idx   <= '0;
        r_parity    <= parity_bit(r_hold, PARITY_ODD);
      end else if (w_accept) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end
      if ((r_state == ST_DATA) && w_tick) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign tx         = r_tx;
  assign data_ready = !r_hold_full;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx : randomized scoreboard bench for uart_tx (even and odd parity)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME = 12 * CPB;

  typedef struct {
    logic [7:0] b;
    int         n;
  } acc_t;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, tx, busy;
  logic       ready_o, tx_o, busy_o;

  int   compared = 0;
  int   mismatched = 0;
  int   n = 0;
  int   prev_end = 0;
  int   off = 0;
  bit   abort = 0;
  bit   pend = 0;
  acc_t q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx(tx), .busy(busy)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_o), .tx(tx_o), .busy(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, n);
    end
  endtask

  // Expected line level of frame bit k: start, 8 data LSB first, parity, 2 stops.
  function automatic logic exp_bit(input logic [7:0] b, input int k, input int par);
    if (k == 0) return 1'b0;
    if (k <= 8) return logic'((b >> (k - 1)) & 8'd1);
    if (k == 9) return logic'(par);
    return 1'b1;
  endfunction

  // Acceptance recorder: whatever sits on data_in at an accepting edge is owed a frame.
  initial begin : p_acc
    forever begin
      @(posedge clk);
      n = n + 1;
      if (!rst && data_valid && data_ready) q.push_back('{b: data_in, n: n});
    end
  end

  task automatic adv(input int tgt);
    while (off < tgt && !abort) begin
      @(negedge clk);
      off++;
    end
  endtask

  initial begin : p_mon
    acc_t e;
    int   p, exp_p, par;
    bit   more;
    forever begin
      if (!pend) @(negedge clk);
      pend = 1'b0;
      if (abort) begin
        abort    = 1'b0;
        prev_end = 0;
      end
      if (!rst && tx === 1'b0) begin
        p   = n;
        off = 0;
        if (q.size() == 0) begin
          chk("frame_without_byte", 32'(q.size()), 1);
          adv(FRAME);
        end else begin
          e     = q.pop_front();
          exp_p = (e.n + 1 > prev_end) ? e.n + 1 : prev_end;
          chk("start_edge", p, exp_p);
          par = $countones(e.b) % 2;
          for (int k = 0; k < 12; k++) begin
            adv(k * CPB + CPB / 2);
            if (abort) break;
            chk($sformatf("even_bit%0d", k), tx, exp_bit(e.b, k, par));
            chk($sformatf("odd_bit%0d", k), tx_o, exp_bit(e.b, k, par ^ 1));
            chk("busy_in_frame", busy, 1);
          end
          adv(FRAME - 1);
          if (!abort) begin
            chk("busy_last_cycle", busy, 1);
            more = (q.size() > 0);
            adv(FRAME);
            if (!abort) begin
              if (more) begin
                chk("contiguous_start", tx, 0);
                pend = 1'b1;
              end else begin
                chk("busy_after_frame", busy, 0);
              end
              prev_end = p + FRAME;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit scramble);
    bit got = 1'b0;
    data_in    = b;
    data_valid = 1'b1;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (data_ready) got = 1'b1;
      else if (scramble) data_in = 8'($urandom);
    end
    if (!got) chk("accept_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 2000 && (busy || q.size() > 0); t++) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_queue", 32'(q.size()), 0);
  endtask

  initial begin : p_main
    rst        = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", data_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_ready", data_ready, 1);
      chk("idle_busy", busy, 0);
    end

    send(8'hA5, 1'b0);
    wait_idle();

    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    wait_idle();

    send(8'h01, 1'b0);
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    wait_idle();

    // Reset while DATA bit 3 of 0x00 is on the line and 0x5A waits in the hold register.
    send(8'h00, 1'b0);
    send(8'h5A, 1'b0);
    repeat (16) @(negedge clk);
    #2;
    chk("pre_rst_tx", tx, 0);
    chk("pre_rst_ready", data_ready, 0);
    rst   = 1'b1;
    abort = 1'b1;
    q.delete();
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_tx_odd", tx_o, 1);
    chk("async_rst_ready", data_ready, 1);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      chk("post_rst_tx", tx, 1);
    end
    chk("post_rst_ready", data_ready, 1);
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      send(8'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle();

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that pairs with the existing UART receiver and produces the same frame format: 1 start bit, 8 data bits LSB first, 1 parity bit, 2 stop bits.
- Takes bytes from on-chip logic through a valid/ready handshake.
- A one-entry holding register lets the next byte be accepted while the current frame shifts out, so consecutive frames go out with no idle gap.
- Default timing is 9600 baud from the 81.25 MHz system clock.

Parameters:
- CLKS_PER_BIT, 8464, clock cycles per serial bit (81.25 MHz / 9600, rounded to match the receiver's count of 0..8463). Legal range 2..16383.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity.

Ports:
- clk  input  1  system clock, 81.25 MHz.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  8  byte to transmit; sampled only on the accept edge.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  holding register is empty; a byte is accepted on a clk edge where data_valid && data_ready.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (asynchronous, active-high):
  - tx=1, data_ready=1, busy=0.
  - Holding register is cleared, FSM goes to IDLE, bit counter and baud counter are 0.
  - Reset asserted mid-frame aborts the frame immediately; tx goes high without waiting for a clock.
  - Any byte in the holding register is discarded and must be re-offered.
- Handshake:
  - Accept edge: hold <= data_in, hold_full <= 1, data_ready <= 0.
  - data_in and data_valid are ignored while data_ready=0.
  - data_ready returns to 1 on the edge where the FSM moves hold into the shift register.
  - A new byte can be accepted on the cycle after that edge.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit.
  - A bit ends on the edge where count == CLKS_PER_BIT-1; the counter then wraps to 0.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE:
    - tx=1.
    - If hold_full: on the next edge load the shift register from hold, compute the parity bit, clear hold_full, set busy=1, enter START with tx=0.
    - Latency: accept edge E0, tx falls at edge E0+1.
  - START: tx=0 for one bit, then DATA with bit index 0.
  - DATA:
    - tx = shift[0] for one bit, then shift right and increment the index.
    - After index 7 completes, go to PARITY.
  - PARITY:
    - Even (PARITY_ODD=0): tx = ^byte.
    - Odd (PARITY_ODD=1): tx = ~^byte.
  - STOP1: tx=1 for one bit, then STOP2.
  - STOP2: tx=1 for one bit. At the end:
    - If hold_full, load it and go directly to START (tx=0 on that edge, no idle gap).
    - Otherwise go to IDLE with busy=0.
- Frame length is exactly 12*CLKS_PER_BIT cycles.
- Simultaneous accept and load: the holding register is written only while empty and read only while full, so the two never collide in one cycle.
- tx is driven from a register, so it has no glitches or combinational paths from its inputs.

Decomposition:
- Shared package / include uart_defs, used by both uart and uart_tx:
  - UART_DATA_BITS=8, UART_STOP_BITS=2, UART_CLKS_PER_BIT=8464.
  - FSM state encodings.
- Sub-module uart_baud_tick:
  - Parameterised down-counter with a synchronous restart input and a one-cycle `tick` output at end of bit.
  - Reusable for a later receiver rework.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset then idle:
  - tx=1, data_ready=1, busy=0 held for 100 cycles with no valid.
- Single byte 0xA5, even parity. Sampling tx mid-bit gives 0, 1,0,1,0,0,1,0,1, parity 0, 1, 1.
  - busy is high for exactly 48 cycles; tx falls 1 cycle after the accept edge.
- Back-to-back 0x00 then 0xFF with valid held high:
  - The second byte is accepted 1 cycle after the first frame starts.
  - Frames are contiguous, with no idle cycles between STOP2 of 0x00 and START of 0xFF.
  - Parity bits are 0 and 0.
- PARITY_ODD=1, byte 0x01:
  - Parity bit = 0.
  - The uart receiver instance connected tx->rx with CLKS_PER_BIT=8464 outputs data_out=0x01 with a data_rdy pulse.
- Reset asserted during DATA bit 3 with hold_full:
  - tx=1 asynchronously, before the next clk edge.
  - After release: data_ready=1, busy=0, and no frame is emitted.
- Stall:
  - data_valid is held with data_in changing while data_ready=0.
  - Only the value present on the accept edge is transmitted.
